// File: rtl/ca_code_bank_pkg.sv
// Shared definitions for the GPS C/A code bank: code length, G1/G2 feedback
// polynomials, channel state encoding and the PRN phase-selector table.
package ca_code_pkg;

    localparam int CA_LEN = 1023;

    // Feedback tap masks, bit n set for each x^n term (bits numbered 10:1)
    localparam logic [10:1] G1_POLY   = 10'b1000000100;
    localparam logic [10:1] G2_POLY   = 10'b1110100110;
    localparam logic [10:1] LFSR_INIT = 10'b1111111111;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_SLEW = 2'd1,
        CH_RUN  = 2'd2
    } ch_state_t;

    typedef struct packed {
        logic [3:0] t1;
        logic [3:0] t2;
    } tap_pair_t;

    function automatic tap_pair_t prn_taps(input logic [5:0] prn);
        tap_pair_t tp;
        tp.t1 = 4'd1;
        tp.t2 = 4'd1;
        case (prn)
            6'd1:  begin tp.t1 = 4'd2; tp.t2 = 4'd6;  end
            6'd2:  begin tp.t1 = 4'd3; tp.t2 = 4'd7;  end
            6'd3:  begin tp.t1 = 4'd4; tp.t2 = 4'd8;  end
            6'd4:  begin tp.t1 = 4'd5; tp.t2 = 4'd9;  end
            6'd5:  begin tp.t1 = 4'd1; tp.t2 = 4'd9;  end
            6'd6:  begin tp.t1 = 4'd2; tp.t2 = 4'd10; end
            6'd7:  begin tp.t1 = 4'd1; tp.t2 = 4'd8;  end
            6'd8:  begin tp.t1 = 4'd2; tp.t2 = 4'd9;  end
            6'd9:  begin tp.t1 = 4'd3; tp.t2 = 4'd10; end
            6'd10: begin tp.t1 = 4'd2; tp.t2 = 4'd3;  end
            6'd11: begin tp.t1 = 4'd3; tp.t2 = 4'd4;  end
            6'd12: begin tp.t1 = 4'd5; tp.t2 = 4'd6;  end
            6'd13: begin tp.t1 = 4'd6; tp.t2 = 4'd7;  end
            6'd14: begin tp.t1 = 4'd7; tp.t2 = 4'd8;  end
            6'd15: begin tp.t1 = 4'd8; tp.t2 = 4'd9;  end
            6'd16: begin tp.t1 = 4'd9; tp.t2 = 4'd10; end
            6'd17: begin tp.t1 = 4'd1; tp.t2 = 4'd4;  end
            6'd18: begin tp.t1 = 4'd2; tp.t2 = 4'd5;  end
            6'd19: begin tp.t1 = 4'd3; tp.t2 = 4'd6;  end
            6'd20: begin tp.t1 = 4'd4; tp.t2 = 4'd7;  end
            6'd21: begin tp.t1 = 4'd5; tp.t2 = 4'd8;  end
            6'd22: begin tp.t1 = 4'd6; tp.t2 = 4'd9;  end
            6'd23: begin tp.t1 = 4'd1; tp.t2 = 4'd3;  end
            6'd24: begin tp.t1 = 4'd4; tp.t2 = 4'd6;  end
            6'd25: begin tp.t1 = 4'd5; tp.t2 = 4'd7;  end
            6'd26: begin tp.t1 = 4'd6; tp.t2 = 4'd8;  end
            6'd27: begin tp.t1 = 4'd7; tp.t2 = 4'd9;  end
            6'd28: begin tp.t1 = 4'd8; tp.t2 = 4'd10; end
            6'd29: begin tp.t1 = 4'd1; tp.t2 = 4'd6;  end
            6'd30: begin tp.t1 = 4'd2; tp.t2 = 4'd7;  end
            6'd31: begin tp.t1 = 4'd3; tp.t2 = 4'd8;  end
            6'd32: begin tp.t1 = 4'd4; tp.t2 = 4'd9;  end
            default: begin tp.t1 = 4'd1; tp.t2 = 4'd1; end
        endcase
        return tp;
    endfunction

    function automatic logic [10:1] lfsr_step(input logic [10:1] g, input logic [10:1] poly);
        return {g[9:1], ^(g & poly)};
    endfunction

endpackage

// File: rtl/ca_code_bank_if.sv
// Configuration request bus for the C/A code bank (valid/ready with error pulse).
interface ca_code_bank_if #(parameter int CHW = 4);

    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [5:0]     cfg_prn;
    logic [9:0]     cfg_phase;
    logic           cfg_err;

    modport master (output cfg_valid, cfg_ch, cfg_prn, cfg_phase, input cfg_ready, cfg_err);
    modport slave  (input cfg_valid, cfg_ch, cfg_prn, cfg_phase, output cfg_ready, cfg_err);

endinterface

// File: rtl/ca_code_bank_chan.sv
// One C/A code channel: G1/G2 LFSRs, chip counter and IDLE/SLEW/RUN control.
// Early/late taps exist only when CA_CODE_BANK_EPL_EN is defined.
module ca_code_chan
    import ca_code_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [5:0] prn,
    input  logic [9:0] phase,
    input  logic       chip_en,
    output logic       prompt,
    output logic       epoch,
    output logic [9:0] chip_cnt,
    output logic       running,
    output logic       slewing
`ifdef CA_CODE_BANK_EPL_EN
    ,
    output logic       early,
    output logic       late
`endif
);

    ch_state_t   state;
    logic [10:1] g1, g2, g1_nxt, g2_nxt;
    tap_pair_t   taps;
    logic [9:0]  cnt, cnt_nxt, target;
    logic        wrap, advance, prompt_raw, epoch_q;

    // At the period wrap both registers are reloaded so the code restarts cleanly
    always_comb begin
        wrap       = (cnt == 10'(CA_LEN - 1));
        cnt_nxt    = wrap ? 10'd0 : cnt + 10'd1;
        g1_nxt     = wrap ? LFSR_INIT : lfsr_step(g1, G1_POLY);
        g2_nxt     = wrap ? LFSR_INIT : lfsr_step(g2, G2_POLY);
        prompt_raw = g1[10] ^ g2[taps.t1] ^ g2[taps.t2];
        advance    = !load && ((state == CH_SLEW) || (state == CH_RUN && chip_en));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CH_IDLE;
            g1      <= LFSR_INIT;
            g2      <= LFSR_INIT;
            cnt     <= 10'd0;
            target  <= 10'd0;
            taps    <= prn_taps(6'd0);
            epoch_q <= 1'b0;
        end else begin
            epoch_q <= 1'b0;
            if (load) begin
                g1     <= LFSR_INIT;
                g2     <= LFSR_INIT;
                cnt    <= 10'd0;
                target <= phase;
                taps   <= prn_taps(prn);
                state  <= (phase == 10'd0) ? CH_RUN : CH_SLEW;
            end else if (advance) begin
                g1  <= g1_nxt;
                g2  <= g2_nxt;
                cnt <= cnt_nxt;
                if (state == CH_SLEW && cnt_nxt == target)
                    state <= CH_RUN;
                if (state == CH_RUN && wrap)
                    epoch_q <= 1'b1;
            end
        end
    end

    assign prompt   = (state != CH_IDLE) && prompt_raw;
    assign epoch    = epoch_q;
    assign chip_cnt = cnt;
    assign running  = (state == CH_RUN);
    assign slewing  = (state == CH_SLEW);

`ifdef CA_CODE_BANK_EPL_EN
    logic late_q;

    always_ff @(posedge clk) begin
        if (rst || load)
            late_q <= 1'b0;
        else if (advance)
            late_q <= prompt_raw;
    end

    assign early = (state != CH_IDLE) && (g1_nxt[10] ^ g2_nxt[taps.t1] ^ g2_nxt[taps.t2]);
    assign late  = late_q;
`endif

endmodule

// File: rtl/ca_code_bank.sv
// Bank of NUM_CH GPS C/A code generators with a shared configuration port.
// Define CA_CODE_BANK_EPL_EN to add per-channel early/late outputs.
module ca_code_bank
    import ca_code_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CHW    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      chip_en,
    ca_code_bank_if.slave          cfg,
    output logic [NUM_CH-1:0]      prompt,
    output logic [NUM_CH-1:0]      epoch,
    output logic [NUM_CH-1:0][9:0] chip_cnt,
    output logic [NUM_CH-1:0]      running
`ifdef CA_CODE_BANK_EPL_EN
    ,
    output logic [NUM_CH-1:0]      early,
    output logic [NUM_CH-1:0]      late
`endif
);

    logic              accept, req_ok, err_q;
    logic [NUM_CH-1:0] load, slewing;

    // Bad requests are still consumed so the master never stalls on them
    always_comb begin
        accept = cfg.cfg_valid && cfg.cfg_ready;
        req_ok = (cfg.cfg_prn != 6'd0) && (cfg.cfg_prn <= 6'd32) &&
                 (cfg.cfg_phase <= 10'd1022) && (int'(cfg.cfg_ch) < NUM_CH);
        load   = '0;
        for (int i = 0; i < NUM_CH; i++)
            load[i] = accept && req_ok && (int'(cfg.cfg_ch) == i);
    end

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else
            err_q <= accept && !req_ok;
    end

    assign cfg.cfg_ready = ~|slewing;
    assign cfg.cfg_err   = err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        ca_code_chan u_chan (
            .clk      (clk),
            .rst      (rst),
            .load     (load[i]),
            .prn      (cfg.cfg_prn),
            .phase    (cfg.cfg_phase),
            .chip_en  (chip_en[i]),
            .prompt   (prompt[i]),
            .epoch    (epoch[i]),
            .chip_cnt (chip_cnt[i]),
            .running  (running[i]),
            .slewing  (slewing[i])
`ifdef CA_CODE_BANK_EPL_EN
            ,
            .early    (early[i]),
            .late     (late[i])
`endif
        );
    end

endmodule
